// File: rtl/ringbuffer_uart_drain.sv
// ringbuffer_uart_drain
// Reader side of the LPC capture ring buffer. While the buffer holds entries
// (and i_enable permits), pops one DW-bit entry and sends it as DW/8 UART 8N1
// bytes, most-significant byte first and each byte LSB first, on o_tx.
//
// Ports:
//   i_clock              system clock, rising edge
//   i_reset              asynchronous active-high reset
//   i_enable             permits starting a new entry (sampled in IDLE only)
//   i_empty              ring buffer empty flag (sampled in IDLE only)
//   i_read_data          ring buffer read data, valid one cycle after the pop
//   o_read_clock_enable  single-cycle pop strobe (registered)
//   o_tx                 UART line, idle high (registered)
//   o_busy               high from the pop strobe to the end of the last stop bit
//   o_dbg_state          current FSM state, for observation
//
// Handshake: the ring buffer read port has no ready/valid pair. A one-cycle
// o_read_clock_enable pulse is the pop; i_read_data is taken exactly two edges
// after the edge that raised the pulse, and a pop is only issued when i_empty=0.
module ringbuffer_uart_drain #(
  parameter int DW      = 48,
  parameter int DIVISOR = 104
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic          i_empty,
  input  logic [DW-1:0] i_read_data,
  output logic          o_read_clock_enable,
  output logic          o_tx,
  output logic          o_busy,
  output logic [2:0]    o_dbg_state
);

  localparam int TW = $clog2(DIVISOR);
  localparam int NB = DW / 8;
  localparam int BW = $clog2(NB) + 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(DIVISOR - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tick;
  logic [2:0]      r_bit_idx;
  logic [BW-1:0]   r_byte_cnt;
  logic [DW-1:0]   r_shift;
  logic            r_tx;
  logic            r_rce;
  logic            r_busy;

  logic [7:0]      w_cur_byte;
  logic [2:0]      w_next_idx;
  logic            w_tick_done;

  assign w_cur_byte  = r_shift[DW-1 -: 8];
  assign w_next_idx  = r_bit_idx + 3'd1;
  assign w_tick_done = (r_tick == TICK_MAX);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_bit_idx  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_rce      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tick <= '0;
          if (i_enable && !i_empty) begin
            r_state <= S_POP;
            r_rce   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_POP: begin
          r_rce   <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Buffer data is valid now; the start bit begins on this same edge.
          r_shift    <= i_read_data;
          r_byte_cnt <= BYTE_LAST;
          r_tick     <= '0;
          r_tx       <= 1'b0;
          r_state    <= S_START;
        end
        S_START: begin
          if (w_tick_done) begin
            r_tick    <= '0;
            r_bit_idx <= '0;
            r_tx      <= w_cur_byte[0];
            r_state   <= S_DATA;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick_done) begin
            r_tick <= '0;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
              r_tx      <= 1'b1;
              r_state   <= S_STOP;
            end else begin
              r_bit_idx <= w_next_idx;
              r_tx      <= w_cur_byte[w_next_idx];
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick_done) begin
            r_tick <= '0;
            if (r_byte_cnt != '0) begin
              // Next byte follows immediately with no idle gap.
              r_shift    <= r_shift << 8;
              r_byte_cnt <= r_byte_cnt - 1'b1;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tick  <= '0;
          r_tx    <= 1'b1;
          r_rce   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_read_clock_enable = r_rce;
  assign o_tx                = r_tx;
  assign o_busy              = r_busy;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_ringbuffer_uart_drain.sv
module tb_ringbuffer_uart_drain;

  localparam int D1 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // DUT 1: DW=48, DIVISOR=4
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        empty = 1'b1;
  logic [47:0] rd = '0;
  logic        rce, tx, busy;
  logic [2:0]  st;

  ringbuffer_uart_drain #(.DW(48), .DIVISOR(D1)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_empty(empty),
    .i_read_data(rd), .o_read_clock_enable(rce), .o_tx(tx), .o_busy(busy),
    .o_dbg_state(st)
  );

  // DUT 2: DW=8, DIVISOR=2
  logic       rst2 = 1'b1;
  logic       en2 = 1'b0;
  logic       empty2 = 1'b1;
  logic [7:0] rd2 = '0;
  logic       rce2, tx2, busy2;
  logic [2:0] st2;

  ringbuffer_uart_drain #(.DW(8), .DIVISOR(2)) dut2 (
    .i_clock(clk), .i_reset(rst2), .i_enable(en2), .i_empty(empty2),
    .i_read_data(rd2), .o_read_clock_enable(rce2), .o_tx(tx2), .o_busy(busy2),
    .o_dbg_state(st2)
  );

  // ---------------- scoreboard / bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [47:0] rb_q[$];
  int          start_q[$];
  int          rx_bytes = 0;
  int          pop_count = 0;
  int          viol = 0;
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [47:0]     rd;
    logic [5:0][7:0] exp_b;  // exp_b[5] is the first byte on the line
  } vec_t;
  vec_t vecs[6];

  task automatic load_rb(input int i);
    rb_q.push_back(vecs[i].rd);
  endtask

  task automatic push_exp(input int i);
    for (int b = 5; b >= 0; b--) exp_q.push_back(vecs[i].exp_b[b]);
  endtask

  // ---------------- ring buffer model + strobe checker ----------------
  logic [47:0] rb_hold = '0;
  logic        rb_pend = 1'b0;
  logic        prev_rce = 1'b0;
  always @(negedge clk) begin
    if (rce) begin
      pop_count++;
      if (st != 3'd1) viol++;
      if (prev_rce) viol++;
      if (rb_q.size() == 0) viol++;
      else rb_hold = rb_q.pop_front();
      rb_pend = 1'b1;
    end else if (rb_pend) begin
      rd = rb_hold;  // valid one cycle after the strobe
      rb_pend = 1'b0;
    end
    prev_rce = rce;
    empty = (rb_q.size() == 0);
  end

  // ---------------- UART monitor for DUT 1 ----------------
  int         m_t = 0;
  logic       m_act = 1'b0;
  logic [7:0] m_byte = '0;
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      m_t = 0;
      m_act = 1'b0;
    end else if (!m_act) begin
      if (tx == 1'b0) begin
        m_act = 1'b1;
        m_t = 0;
        start_q.push_back(cyc);
      end
    end else begin
      m_t++;
    end
    if (m_act) begin
      if (m_t % D1 == D1 / 2) begin
        int k;
        k = m_t / D1;
        if (k == 0) chk("start_bit", tx, 1'b0);
        else if (k <= 8) m_byte[k-1] = tx;
        else begin
          chk("stop_bit", tx, 1'b1);
          rx_bytes++;
          if (exp_q.size() == 0) chk("unexpected_byte", m_byte, 64'hFFFF_FFFF);
          else chk("uart_byte", m_byte, exp_q.pop_front());
        end
      end
      if (m_t == 10 * D1 - 1) m_act = 1'b0;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bytes(input int target, input int bound);
    int n = 0;
    while (rx_bytes < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait_bytes", rx_bytes, target);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", busy, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  int p0, rx0, bad, n, t_end;
  logic [31:0] r1, r2;
  logic [9:0]  pat;

  initial begin
    vecs[0].rd = 48'h0123456789AB; vecs[0].exp_b = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    vecs[1].rd = 48'h111111111111; vecs[1].exp_b = {8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
    vecs[2].rd = 48'h222222222222; vecs[2].exp_b = {8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22};
    vecs[3].rd = 48'hFF005A3CC381; vecs[3].exp_b = {8'hFF, 8'h00, 8'h5A, 8'h3C, 8'hC3, 8'h81};
    r1 = $urandom_range(32'hFFFF_FFFF, 0);
    r2 = $urandom_range(32'h0000_FFFF, 0);
    vecs[4].rd = {r1, r2[15:0]};
    vecs[4].exp_b = {r1[31:24], r1[23:16], r1[15:8], r1[7:0], r2[15:8], r2[7:0]};
    vecs[5].rd = 48'h80017E42BD18; vecs[5].exp_b = {8'h80, 8'h01, 8'h7E, 8'h42, 8'hBD, 8'h18};

    // Reset values held for 3 cycles with work pending, then first entry.
    rst = 1'b1; en = 1'b1; mon_en = 1'b1;
    load_rb(0); push_exp(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_rce", rce, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end
    chk("rst_state", st, 3'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("first_pop", rce, 1'b1);
    chk("first_pop_busy", busy, 1'b1);
    @(negedge clk);
    chk("pop_single_cycle", rce, 1'b0);
    wait_bytes(6, 400);
    wait_idle(100);
    t_end = cyc;
    chk("entry_240_clocks", t_end - start_q[0], 240);
    for (int i = 0; i < 5; i++) chk("byte_40_clocks", start_q[i+1] - start_q[i], 40);
    chk("single_pop", pop_count, 1);

    // Back-to-back entries.
    start_q.delete(); rx0 = rx_bytes; p0 = pop_count;
    load_rb(1); push_exp(1); load_rb(2); push_exp(2);
    wait_bytes(rx0 + 12, 1200);
    wait_idle(100);
    chk("b2b_pops", pop_count - p0, 2);
    chk("b2b_starts", start_q.size(), 12);
    chk("b2b_intra_gap", start_q[5] - start_q[4], 40);
    chk("b2b_inter_gap", start_q[6] - start_q[5], 43);

    // Empty gating.
    p0 = pop_count; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || rce !== 1'b0) bad++;
    end
    chk("empty_gate", bad, 0);
    chk("empty_no_pop", pop_count - p0, 0);

    // enable=0 holds off; dropping enable mid-entry lets the entry finish.
    en = 1'b0; rx0 = rx_bytes;
    load_rb(3); push_exp(3);
    tick(200);
    chk("enable_gate_pop", pop_count - p0, 0);
    chk("enable_gate_busy", busy, 1'b0);
    en = 1'b1;
    wait_bytes(rx0 + 2, 400);
    en = 1'b0;
    load_rb(4);
    wait_bytes(rx0 + 6, 600);
    wait_idle(100);
    tick(300);
    chk("enable_drop_pops", pop_count - p0, 1);
    chk("enable_drop_bytes", rx_bytes, rx0 + 6);

    // Reset during DATA of byte 3; next entry starts at its byte 0.
    exp_q.push_back(vecs[4].exp_b[5]);
    exp_q.push_back(vecs[4].exp_b[4]);
    p0 = pop_count; rx0 = rx_bytes;
    en = 1'b1;
    wait_bytes(rx0 + 2, 600);
    n = 0;
    while (st != 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_data_byte3", st, 3'd4);
    tick(5);
    #2 mon_en = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rce", rce, 1'b0);
    chk("midrst_state", st, 3'd0);
    load_rb(5); push_exp(5);
    tick(3);
    #2 rst = 1'b0; mon_en = 1'b1;
    wait_bytes(rx0 + 8, 800);
    wait_idle(100);
    chk("midrst_pops", pop_count - p0, 2);
    chk("scoreboard_drained", exp_q.size(), 0);

    // Minimum divisor, DW=8: 0xA5 -> 0,1,0,1,0,0,1,0,1,1 at 2 clocks per bit.
    pat = 10'b1101001010;
    en2 = 1'b1; rd2 = 8'hA5; empty2 = 1'b0;
    @(negedge clk);
    #2 rst2 = 1'b0;
    n = 0;
    @(negedge clk);
    while (tx2 != 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("min_div_start", tx2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("min_div_bit", tx2, pat[i/2]);
      @(negedge clk);
    end
    chk("min_div_done_busy", busy2, 1'b0);
    empty2 = 1'b1;

    chk("strobe_violations", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ringbuffer_uart_drain.md
# ringbuffer_uart_drain

Reader side of the LPC capture ring buffer. Whenever the ring buffer holds entries, this block pops one DW-bit entry, serialises it as DW/8 UART 8N1 bytes (most-significant byte first) on a single TX line, and repeats until the buffer is empty. It sits between the ring buffer's read port and the board's UART pin, so captured LPC cycles reach the host without CPU involvement.

## Interface
- DW, 48, entry width in bits; must be a multiple of 8, minimum 8
- DIVISOR, 104, clocks per UART bit (12 MHz / 115200); minimum 2

- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  permits starting a new entry; sampled only in IDLE
- empty  in  1  ring buffer empty flag
- read_data  in  DW  ring buffer read data, valid one cycle after the pop
- read_clock_enable  out  1  single-cycle pop strobe to the ring buffer
- tx  out  1  UART serial output, idle high
- busy  out  1  high from pop strobe until the last stop bit of the entry ends

## Operation
- States: IDLE, POP, WAIT, START, DATA, STOP.
- IDLE: if enable=1 and empty=0 on a rising edge, go to POP. Otherwise stay in IDLE.
- POP: read_clock_enable=1 for exactly this one cycle, then go to WAIT.
- WAIT: one cycle, then capture read_data into a DW-bit shift register, set byte counter to DW/8-1, and go to START.
- START: tx=0 for DIVISOR clocks.
- DATA: send the current top byte (bits [DW-1:DW-8]) LSB first. Each bit lasts DIVISOR clocks, 8 bits in total.
- STOP: tx=1 for DIVISOR clocks. At the end of STOP:
  - If the byte counter is not 0: shift the register left by 8, decrement the counter, and go to START.
  - If the counter is 0: go to IDLE.
- Counters:
  - Bit-timing counter is clog2(DIVISOR) bits wide and counts 0..DIVISOR-1.
  - Bit index is 3 bits.
  - Byte counter is clog2(DW/8)+1 bits wide.
  - No counter may wrap outside its stated range.
- read_clock_enable is never asserted outside POP. It is therefore never asserted while empty=1 or while an entry is in flight.
- enable=0 mid-entry has no effect; the current entry always completes.
- busy=1 in POP, WAIT, START, DATA and STOP; busy=0 in IDLE.
- tx, read_clock_enable and busy are registered outputs (no combinational path from inputs).

## Timing
- Reset values: tx=1, read_clock_enable=0, busy=0, state IDLE, all counters 0, shift register 0.
- Reset asserted mid-entry:
  - All outputs take their reset values immediately (asynchronous).
  - The popped entry is discarded and is not resent.
  - A partial byte may appear on the line; the host resynchronises on idle.
- Edge E samples enable=1, empty=0 in IDLE:
  - read_clock_enable=1 during cycle E..E+1, then 0.
  - read_data is captured at edge E+2.
  - tx falls at edge E+2.
- Each byte occupies 10*DIVISOR clocks. Bytes of one entry are back-to-back with no idle gap.
- Entry duration from tx falling edge to end of the last stop bit: (DW/8)*10*DIVISOR clocks.
- Between entries, with empty=0 throughout: IDLE lasts one cycle, so the next tx falling edge comes 3 clocks after the previous stop bit ends.
- empty rising in the same cycle as the IDLE check: no pop. empty is sampled only in IDLE.

## Test plan
- Reset values: hold reset high for 3 cycles with empty=0 and enable=1 -> tx=1, read_clock_enable=0, busy=0 throughout; first pop strobe 1 cycle after reset falls.
- Single entry, DW=48, DIVISOR=4, read_data=0x0123456789AB presented one cycle after the pop strobe:
  - UART decoder sees bytes 01,23,45,67,89,AB in that order.
  - Each byte is 40 clocks; total 240 clocks from tx falling edge.
  - Exactly one pop strobe.
- Back-to-back entries: empty=0 for two entries (0x111111111111, 0x222222222222) with DIVISOR=4:
  - Exactly 2 single-cycle strobes.
  - 3-clock gap between the last stop bit of entry 1 and the start bit of entry 2.
  - 12 bytes received correctly.
- Empty and enable gating:
  - empty=1 for 1000 cycles -> no strobe, tx=1, busy=0.
  - enable=0 with empty=0 -> no strobe.
  - enable dropped to 0 after the 2nd byte -> entry completes (6 bytes) and no further pop occurs.
- Reset mid-byte: assert reset during DATA of byte 3 -> tx=1 in the same cycle as reset, busy=0. After release with empty=0, a new entry starts with byte 0 of the next read_data.
- Minimum divisor, DIVISOR=2, DW=8, read_data=0xA5: tx bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 2 clocks, total 20 clocks.
